// File: rtl/nd_2to1_arb.sv
// Fair 2-to-1 merge node: two 4-phase req/ack input channels feed one FIFO
// that drains, in acceptance order, into a single 4-phase output channel.
module nd_2to1_arb #(
  parameter int unsigned FSZ   = 4,
  parameter int unsigned ASZ   = 8,
  parameter int unsigned DSZ   = 8,
  parameter int unsigned RSZ   = 4,
  parameter bit          PRIO0 = 1'b0
) (
  input  logic           i_clk,
  input  logic           reset,
  output logic           ready,
  input  logic           rcv0_req,
  output logic           rcv0_ack,
  input  logic [ASZ-1:0] rcv0_src,
  input  logic [ASZ-1:0] rcv0_dst,
  input  logic [DSZ-1:0] rcv0_dat,
  input  logic [RSZ-1:0] rcv0_red,
  input  logic           rcv1_req,
  output logic           rcv1_ack,
  input  logic [ASZ-1:0] rcv1_src,
  input  logic [ASZ-1:0] rcv1_dst,
  input  logic [DSZ-1:0] rcv1_dat,
  input  logic [RSZ-1:0] rcv1_red,
  output logic           snd_req,
  input  logic           snd_ack,
  output logic [ASZ-1:0] snd_src,
  output logic [ASZ-1:0] snd_dst,
  output logic [DSZ-1:0] snd_dat,
  output logic [RSZ-1:0] snd_red
);

  localparam int unsigned MSZ = 2 * ASZ + DSZ + RSZ;
  localparam int unsigned PW  = (FSZ > 1) ? $clog2(FSZ) : 1;
  localparam int unsigned CW  = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FSZ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_LOW
  } snd_state_t;

  logic [MSZ-1:0] mem [FSZ];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           rr_ptr;
  logic           init_done;
  snd_state_t     state;

  logic           elig0_c;
  logic           elig1_c;
  logic           grant0_c;
  logic           grant1_c;
  logic           push_c;
  logic           pop_c;
  logic [MSZ-1:0] wr_msg_c;
  logic [MSZ-1:0] head_c;

  // Input arbitration: one grant per cycle, pointer or fixed priority on contention
  always_comb begin
    elig0_c  = ready && rcv0_req && !rcv0_ack && (count < FULL);
    elig1_c  = ready && rcv1_req && !rcv1_ack && (count < FULL);
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    if (elig0_c && elig1_c) begin
      if (PRIO0 || !rr_ptr) grant0_c = 1'b1;
      else                  grant1_c = 1'b1;
    end else begin
      grant0_c = elig0_c;
      grant1_c = elig1_c;
    end
    push_c   = grant0_c || grant1_c;
    wr_msg_c = grant1_c ? {rcv1_src, rcv1_dst, rcv1_dat, rcv1_red}
                        : {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red};
    head_c   = mem[rd_ptr];
    // The output register reloads from IDLE, or straight out of WAIT_LOW once ack drops
    pop_c    = ready && (count != '0) &&
               ((state == S_IDLE) || ((state == S_WAIT_LOW) && !snd_ack));
  end

  // FIFO storage; contents need no reset because pointers and count gate visibility
  always_ff @(posedge i_clk) begin
    if (push_c) mem[wr_ptr] <= wr_msg_c;
  end

  // Init sequencing, input acks, FIFO pointers and the output handshake FSM
  always_ff @(posedge i_clk) begin
    if (!reset) begin
      init_done <= 1'b0;
      ready     <= 1'b0;
      rcv0_ack  <= 1'b0;
      rcv1_ack  <= 1'b0;
      snd_req   <= 1'b0;
      snd_src   <= '0;
      snd_dst   <= '0;
      snd_dat   <= '0;
      snd_red   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rr_ptr    <= 1'b0;
      state     <= S_IDLE;
    end else begin
      init_done <= 1'b1;
      ready     <= init_done;

      if (grant0_c)      rcv0_ack <= 1'b1;
      else if (!rcv0_req) rcv0_ack <= 1'b0;
      if (grant1_c)      rcv1_ack <= 1'b1;
      else if (!rcv1_req) rcv1_ack <= 1'b0;

      // Pointer names the channel that was not served last
      if (push_c) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= grant0_c;
      end

      if (push_c && !pop_c)      count <= count + 1'b1;
      else if (!push_c && pop_c) count <= count - 1'b1;

      case (state)
        S_IDLE: ;
        S_REQ: begin
          if (snd_ack) begin
            snd_req <= 1'b0;
            state   <= S_WAIT_LOW;
          end
        end
        S_WAIT_LOW: begin
          if (!snd_ack) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (pop_c) begin
        {snd_src, snd_dst, snd_dat, snd_red} <= head_c;
        snd_req <= 1'b1;
        rd_ptr  <= rd_ptr + 1'b1;
        state   <= S_REQ;
      end
    end
  end

endmodule
